// File: rtl/move_executor.sv
// rtl/move_executor.sv - turn/pause/drive sequencer for a two-motor differential drive
//
// Runs one move command at a time. A move is a turn of N 15-degree steps,
// then a pause with both motors stopped, then a forward drive of D inches.
// It tracks the heading in 15-degree units (0..23). Every output comes
// straight from a register.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high
//   move_command     [11:8] signed turn steps (+ = CCW), [7:0] distance in inches
//   command_valid    move_command is offered this cycle
//   command_ready    high in IDLE; a command is accepted when valid && ready
//   abort            stop the current move and finish through DONE
//   orientation_load load orientation_in (IDLE only)
//   orientation_in   heading to load, 0..23
//   orientation      tracked heading, 0..23
//   motor_left/right {fwd,rev}: 10 forward, 01 reverse, 00 stop
//   busy             high in every state except IDLE
//   done             one-cycle pulse when a move finishes or is aborted
module move_executor #(
    parameter int unsigned CYCLES_PER_STEP = 5400000,
    parameter int unsigned CYCLES_PER_INCH = 2700000,
    parameter int unsigned PAUSE_CYCLES    = 2700000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] move_command,
    input  logic        command_valid,
    output logic        command_ready,
    input  logic        abort,
    input  logic        orientation_load,
    input  logic [4:0]  orientation_in,
    output logic [4:0]  orientation,
    output logic [1:0]  motor_left,
    output logic [1:0]  motor_right,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TURN  = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_DRIVE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_STOP = 2'b00;
    localparam logic [1:0] M_FWD  = 2'b10;
    localparam logic [1:0] M_REV  = 2'b01;

    logic [2:0]  state, state_next;
    logic [31:0] count, count_next;
    logic [11:0] cmd, cmd_next;
    logic [4:0]  orient_next;
    logic [1:0]  left_next, right_next;

    // |turn| * CYCLES_PER_STEP; a turn of -8 has magnitude 8.
    function automatic logic [31:0] step_cycles(input logic [3:0] t);
        logic [3:0] m;
        m = t[3] ? (~t + 4'd1) : t;
        return {28'd0, m} * 32'(CYCLES_PER_STEP);
    endfunction

    function automatic logic [31:0] drive_cycles(input logic [7:0] d);
        return {24'd0, d} * 32'(CYCLES_PER_INCH);
    endfunction

    // The sum lies in -8..30, so a single +/-24 correction is enough.
    function automatic logic [4:0] turn_wrap(input logic [4:0] o, input logic [3:0] t);
        logic signed [6:0] s;
        s = $signed({2'b00, o}) + $signed({{3{t[3]}}, t});
        if (s < 7'sd0)
            s = s + 7'sd24;
        else if (s > 7'sd23)
            s = s - 7'sd24;
        return s[4:0];
    endfunction

    // The counter holds the cycles left in the current state minus one.
    // It reloads on every state entry, and the state exits when it is zero.
    always_comb begin
        state_next  = state;
        count_next  = count;
        cmd_next    = cmd;
        orient_next = orientation;
        case (state)
            S_IDLE: begin
                count_next = 32'd0;
                if (orientation_load)
                    orient_next = orientation_in;
                if (command_valid) begin
                    cmd_next = move_command;
                    if (move_command[11:8] != 4'd0) begin
                        state_next = S_TURN;
                        count_next = step_cycles(move_command[11:8]) - 32'd1;
                    end else if (move_command[7:0] != 8'd0) begin
                        state_next = S_DRIVE;
                        count_next = drive_cycles(move_command[7:0]) - 32'd1;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_TURN: begin
                count_next = count - 32'd1;
                if (abort) begin
                    state_next = S_DONE;
                    count_next = 32'd0;
                end else if (count == 32'd0) begin
                    orient_next = turn_wrap(orientation, cmd[11:8]);
                    if (cmd[7:0] != 8'd0) begin
                        state_next = S_PAUSE;
                        count_next = 32'(PAUSE_CYCLES) - 32'd1;
                    end else begin
                        state_next = S_DONE;
                        count_next = 32'd0;
                    end
                end
            end
            S_PAUSE: begin
                count_next = count - 32'd1;
                if (abort) begin
                    state_next = S_DONE;
                    count_next = 32'd0;
                end else if (count == 32'd0) begin
                    state_next = S_DRIVE;
                    count_next = drive_cycles(cmd[7:0]) - 32'd1;
                end
            end
            S_DRIVE: begin
                count_next = count - 32'd1;
                if (abort || count == 32'd0) begin
                    state_next = S_DONE;
                    count_next = 32'd0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                count_next = 32'd0;
            end
            default: begin
                state_next = S_IDLE;
                count_next = 32'd0;
            end
        endcase
    end

    // Motor outputs are decoded from the next state. This lets them
    // change on the same edge as the state they belong to.
    always_comb begin
        left_next  = M_STOP;
        right_next = M_STOP;
        case (state_next)
            S_TURN: begin
                if (cmd_next[11]) begin
                    left_next  = M_FWD;
                    right_next = M_REV;
                end else begin
                    left_next  = M_REV;
                    right_next = M_FWD;
                end
            end
            S_DRIVE: begin
                left_next  = M_FWD;
                right_next = M_FWD;
            end
            default: begin
                left_next  = M_STOP;
                right_next = M_STOP;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= 32'd0;
            cmd           <= 12'd0;
            orientation   <= 5'd0;
            motor_left    <= M_STOP;
            motor_right   <= M_STOP;
            busy          <= 1'b0;
            done          <= 1'b0;
            command_ready <= 1'b1;
        end else begin
            state         <= state_next;
            count         <= count_next;
            cmd           <= cmd_next;
            orientation   <= orient_next;
            motor_left    <= left_next;
            motor_right   <= right_next;
            busy          <= (state_next != S_IDLE);
            done          <= (state_next == S_DONE);
            command_ready <= (state_next == S_IDLE);
        end
    end

endmodule

// File: tb/tb_move_executor.sv
// tb/tb_move_executor.sv - self-checking bench for move_executor
module tb_move_executor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] move_command = 12'd0;
    logic        command_valid = 1'b0;
    logic        command_ready;
    logic        abort = 1'b0;
    logic        orientation_load = 1'b0;
    logic [4:0]  orientation_in = 5'd0;
    logic [4:0]  orientation;
    logic [1:0]  motor_left, motor_right;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    move_executor #(
        .CYCLES_PER_STEP(4),
        .CYCLES_PER_INCH(3),
        .PAUSE_CYCLES   (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .move_command    (move_command),
        .command_valid   (command_valid),
        .command_ready   (command_ready),
        .abort           (abort),
        .orientation_load(orientation_load),
        .orientation_in  (orientation_in),
        .orientation     (orientation),
        .motor_left      (motor_left),
        .motor_right     (motor_right),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    // Phases of a move as seen from outside.
    localparam int P_IDLE = 0, P_TURN = 1, P_PAUSE = 2, P_DRIVE = 3, P_DONE = 4;

    typedef struct {
        logic [4:0]  orient;
        logic [11:0] cmd;
        int          abort_at;   // busy-cycle index at which abort is raised, -1 none
        int          turn_cyc;
        int          dir;        // +1 CCW, -1 CW, 0 none
        int          pause_cyc;
        int          drive_cyc;
        logic [4:0]  final_o;    // heading once the turn completes
        bit          hold;       // keep valid/load asserted while busy
    } vec_t;

    // {motor_left, motor_right, busy, done, ready, orientation}
    function automatic logic [11:0] exp_of(input int p, input int dir, input logic [4:0] o);
        logic [1:0] l, r;
        logic b, d, rdy;
        l = 2'b00; r = 2'b00; b = 1'b1; d = 1'b0; rdy = 1'b0;
        case (p)
            P_TURN:  begin l = (dir > 0) ? 2'b01 : 2'b10; r = (dir > 0) ? 2'b10 : 2'b01; end
            P_DRIVE: begin l = 2'b10; r = 2'b10; end
            P_DONE:  d = 1'b1;
            P_IDLE:  begin b = 1'b0; rdy = 1'b1; end
            default: ;
        endcase
        return {l, r, b, d, rdy, o};
    endfunction

    function automatic logic [11:0] act_of();
        return {motor_left, motor_right, busy, done, command_ready, orientation};
    endfunction

    task automatic check(input string name, input int cyc, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got ml=%b mr=%b busy=%b done=%b ready=%b orient=%0d, want ml=%b mr=%b busy=%b done=%b ready=%b orient=%0d",
                     name, cyc, act[11:10], act[9:8], act[7], act[6], act[5], act[4:0],
                     exp[11:10], exp[9:8], exp[7], exp[6], exp[5], exp[4:0]);
        end
    endtask

    // Loads the heading and offers the command on the same edge, then checks
    // every busy cycle and the first idle cycle after it.
    task automatic run_vec(input string name, input vec_t v);
        int ph[$];
        bit turn_abort;
        logic [4:0] o_post;
        for (int k = 0; k < v.turn_cyc; k++)  ph.push_back(P_TURN);
        for (int k = 0; k < v.pause_cyc; k++) ph.push_back(P_PAUSE);
        for (int k = 0; k < v.drive_cyc; k++) ph.push_back(P_DRIVE);
        turn_abort = 1'b0;
        if (v.abort_at >= 0 && v.abort_at < ph.size()) begin
            turn_abort = (ph[v.abort_at] == P_TURN);
            while (ph.size() > v.abort_at + 1) void'(ph.pop_back());
        end
        ph.push_back(P_DONE);
        ph.push_back(P_IDLE);
        o_post = turn_abort ? v.orient : v.final_o;

        @(negedge clock);
        orientation_load = 1'b1;
        orientation_in   = v.orient;
        move_command     = v.cmd;
        command_valid    = 1'b1;
        @(posedge clock);
        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clock);
            check(name, i, act_of(), exp_of(ph[i], v.dir, (ph[i] == P_TURN) ? v.orient : o_post));
            if (!v.hold || ph[i] == P_IDLE) begin
                command_valid    = 1'b0;
                orientation_load = 1'b0;
            end else begin
                move_command   = 12'h1FF;
                orientation_in = 5'd16;
            end
            abort = (i == v.abort_at);
        end
        abort = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vec_t rv;
        int t, d, total, st;

        vecs[0] = '{5'd1,  12'h205, -1, 8,  1, 2, 15, 5'd3,  1'b0};
        vecs[1] = '{5'd22, 12'h300, -1, 12, 1, 0, 0,  5'd1,  1'b0};
        vecs[2] = '{5'd1,  12'hD00, -1, 12, -1, 0, 0, 5'd22, 1'b0};
        vecs[3] = '{5'd0,  12'h800, -1, 32, -1, 0, 0, 5'd16, 1'b0};
        vecs[4] = '{5'd4,  12'h000, -1, 0,  0, 0, 0,  5'd4,  1'b0};
        vecs[5] = '{5'd4,  12'h004, -1, 0,  0, 0, 12, 5'd4,  1'b0};
        vecs[6] = '{5'd5,  12'h205, 3,  8,  1, 2, 15, 5'd7,  1'b0};
        vecs[7] = '{5'd5,  12'h205, 12, 8,  1, 2, 15, 5'd7,  1'b0};
        vecs[8] = '{5'd23, 12'h701, -1, 28, 1, 2, 3,  5'd6,  1'b0};
        vecs[9] = '{5'd10, 12'h902, -1, 28, -1, 2, 6, 5'd3,  1'b1};

        // Reset state.
        #2 reset = 1'b1;
        #2 check("reset_state", 0, act_of(), exp_of(P_IDLE, 0, 5'd0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after_reset", 0, act_of(), exp_of(P_IDLE, 0, 5'd0));

        for (int k = 0; k < 10; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // Abort in IDLE has no effect.
        abort = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("abort_idle", 0, act_of(), exp_of(P_IDLE, 0, 5'd10 - 5'd7));

        // Abort together with a valid command in IDLE: the command is accepted.
        move_command  = 12'h001;
        command_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        abort = 1'b0;
        command_valid = 1'b0;
        check("abort_accept", 0, act_of(), exp_of(P_DRIVE, 0, 5'd3));
        @(negedge clock); check("abort_accept", 1, act_of(), exp_of(P_DRIVE, 0, 5'd3));
        @(negedge clock); check("abort_accept", 2, act_of(), exp_of(P_DRIVE, 0, 5'd3));
        @(negedge clock); check("abort_accept", 3, act_of(), exp_of(P_DONE, 0, 5'd3));
        @(negedge clock); check("abort_accept", 4, act_of(), exp_of(P_IDLE, 0, 5'd3));

        // Randomised moves against the phase model.
        for (int k = 0; k < 20; k++) begin
            t  = $urandom_range(0, 15);
            d  = $urandom_range(0, 8);
            st = $urandom_range(0, 23);
            rv.cmd       = {4'(t), 8'(d)};
            if (t >= 8) t = t - 16;
            rv.orient    = 5'(st);
            rv.dir       = (t > 0) ? 1 : (t < 0) ? -1 : 0;
            rv.turn_cyc  = ((t < 0) ? -t : t) * 4;
            rv.pause_cyc = (t != 0 && d != 0) ? 2 : 0;
            rv.drive_cyc = d * 3;
            rv.final_o   = 5'((st + t + 24) % 24);
            rv.hold      = 1'($urandom_range(0, 1));
            total = rv.turn_cyc + rv.pause_cyc + rv.drive_cyc;
            rv.abort_at  = (total > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_vec($sformatf("rand%0d", k), rv);
        end

        // Asynchronous reset in the middle of DRIVE.
        @(negedge clock);
        orientation_load = 1'b1;
        orientation_in   = 5'd9;
        move_command     = 12'h003;
        command_valid    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        orientation_load = 1'b0;
        command_valid    = 1'b0;
        check("pre_reset_drive", 0, act_of(), exp_of(P_DRIVE, 0, 5'd9));
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check("mid_drive_reset", 0, act_of(), exp_of(P_IDLE, 0, 5'd0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_idle", 0, act_of(), exp_of(P_IDLE, 0, 5'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 Parameter CYCLES_PER_STEP, default 5400000, clock cycles of spin per 15-degree turn step.
REQ-002 Parameter CYCLES_PER_INCH, default 2700000, clock cycles of forward drive per inch.
REQ-003 Parameter PAUSE_CYCLES, default 2700000, stopped cycles between turn and drive.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 move_command  input  12  [11:8] signed two's-complement turn in 15-degree steps (positive = CCW, range -8..+7); [7:0] unsigned distance in inches.
REQ-007 command_valid  input  1  move_command is valid this cycle.
REQ-008 command_ready  output  1  block can accept a command.
REQ-009 abort  input  1  synchronous stop request.
REQ-010 orientation_load  input  1  load orientation_in into orientation (accepted in IDLE only).
REQ-011 orientation_in  input  5  heading in 15-degree units, 0..23.
REQ-012 orientation  output  5  tracked heading, 0..23.
REQ-013 motor_left  output  2  {fwd,rev}: 10 forward, 01 reverse, 00 stop.
REQ-014 motor_right  output  2  same encoding as motor_left.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a command finishes or is aborted.

Function
REQ-017 States SHALL be IDLE, TURN, PAUSE, DRIVE, DONE; all outputs registered.
REQ-018 command_ready SHALL be 1 exactly when state is IDLE; a command is accepted on an edge with command_valid=1 and command_ready=1; move_command is latched at acceptance.
REQ-019 command_valid outside IDLE SHALL be ignored, with no queuing.
REQ-020 On acceptance with turn!=0, the next state SHALL be TURN; with turn=0 and distance!=0, DRIVE; with both 0, DONE.
REQ-021 TURN SHALL last exactly |turn|*CYCLES_PER_STEP cycles. Positive turn: motor_left=01, motor_right=10. Negative turn: motor_left=10, motor_right=01. Magnitude of -8 is 8.
REQ-022 At TURN exit, orientation SHALL become (orientation+turn) mod 24, wrapping both directions.
REQ-023 TURN SHALL exit to PAUSE if distance!=0, else to DONE.
REQ-024 PAUSE SHALL last exactly PAUSE_CYCLES cycles with both motors 00, then go to DRIVE.
REQ-025 DRIVE SHALL last exactly distance*CYCLES_PER_INCH cycles with both motors 10, then go to DONE.
REQ-026 DONE SHALL last one cycle with done=1 and motors 00, then return to IDLE.
REQ-027 motor_left=11 or motor_right=11 SHALL never occur.
REQ-028 The duration counter SHALL be at least 32 bits wide and SHALL reload on every state entry.
REQ-029 abort in TURN, PAUSE, or DRIVE SHALL force DONE on the next edge, with motors 00 from that edge.
REQ-030 abort in TURN SHALL leave orientation unchanged; abort in PAUSE or DRIVE SHALL keep the completed turn update.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 abort and command_valid together in IDLE: the command SHALL be accepted.
REQ-033 orientation_load outside IDLE SHALL be ignored.
REQ-034 orientation_load with command acceptance on the same edge: orientation_in SHALL be loaded, and the turn SHALL apply relative to the loaded value at TURN exit.

Reset
REQ-035 reset=1 SHALL immediately force: state IDLE, orientation 0, motors 00, busy 0, done 0, command_ready 1, counter 0, latched command 0, including in the middle of TURN or DRIVE.

Verification
Bench parameters: CYCLES_PER_STEP=4, CYCLES_PER_INCH=3, PAUSE_CYCLES=2.
REQ-036 Reset check: assert reset asynchronously mid-cycle during DRIVE -> motors 00, orientation 0, command_ready 1 before the next edge.
REQ-037 Full command: orientation 1, command {4'h2,8'h05} -> CCW 8 cycles, stop 2 cycles, forward 15 cycles, done pulse of 1 cycle; final orientation 3; command_ready returns 1 cycle after done.
REQ-038 Turn wrap-around cases:
- orientation 22, command {4'h3,8'h00} -> CCW 12 cycles, no pause or drive, orientation 1.
- orientation 1, command {4'hD,8'h00} -> CW 12 cycles, orientation 22.
- command {4'h8,8'h00} -> CW 32 cycles.
REQ-039 Zero fields:
- {4'h0,8'h00} -> done pulse on the cycle after acceptance, motors never non-zero.
- {4'h0,8'h04} -> forward 12 cycles immediately, orientation unchanged.
REQ-040 Abort:
- orientation 5, command {4'h2,8'h05}, abort at TURN cycle 3 -> motors 00 on the next edge, done pulse, orientation 5.
- same command, abort in DRIVE -> orientation 7.
REQ-041 Handshake: command_valid held high during a command -> second command ignored until IDLE; orientation_load during DRIVE -> no effect.
